// File: rtl/pvr_ra_pkg.sv
`default_nettype none
// ============================================================================
// pvr_ra_pkg : Region Array definitions shared by the RA writer and RA parser.
// Rev 1.0
// ============================================================================
package pvr_ra_pkg;

    typedef enum logic [3:0] {
        RA_IDLE = 4'd0,
        RA_CTRL = 4'd1,
        RA_OPQ  = 4'd2,
        RA_OPQM = 4'd3,
        RA_TRN  = 4'd4,
        RA_TRNM = 4'd5,
        RA_PT   = 4'd6,
        RA_NEXT = 4'd7,
        RA_DONE = 4'd8
    } ra_state_t;

    localparam int c_ctrl_last   = 31;
    localparam int c_ctrl_zclear = 30;
    localparam int c_ctrl_flush  = 28;
    localparam int c_tiley_hi    = 13;
    localparam int c_tiley_lo    = 8;
    localparam int c_tilex_hi    = 7;
    localparam int c_tilex_lo    = 2;

    localparam logic [31:0] c_empty_ptr = 32'h8000_0000;

    localparam int c_words_v1 = 5;
    localparam int c_words_v2 = 6;

    function automatic logic [31:0] ra_ctrl_word(input logic       last,
                                                 input logic       zclear,
                                                 input logic       flush,
                                                 input logic [5:0] y,
                                                 input logic [5:0] x);
        logic [31:0] w;
        w                          = '0;
        w[c_ctrl_last]             = last;
        w[c_ctrl_zclear]           = zclear;
        w[c_ctrl_flush]            = flush;
        w[c_tiley_hi:c_tiley_lo]   = y;
        w[c_tilex_hi:c_tilex_lo]   = x;
        return w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ra_writer_if.sv
`default_nettype none
// ============================================================================
// ra_writer_if : VRAM write-port bundle between the RA writer and the arbiter.
// Rev 1.0
// ============================================================================
interface ra_writer_if #(
    parameter int ADDR_W = 24
);
    logic              ra_vram_wr;
    logic [ADDR_W-1:0] ra_vram_addr;
    logic [31:0]       ra_vram_dout;
    logic              ra_vram_wait;

    modport master (
        output ra_vram_wr,
        output ra_vram_addr,
        output ra_vram_dout,
        input  ra_vram_wait
    );

    modport slave (
        input  ra_vram_wr,
        input  ra_vram_addr,
        input  ra_vram_dout,
        output ra_vram_wait
    );
endinterface
`default_nettype wire

// File: rtl/ra_tile_walker.sv
`default_nettype none
// ============================================================================
// ra_tile_walker : row-major tile x/y counters with look-ahead of next position.
// Rev 1.0
// ============================================================================
module ra_tile_walker #(
    parameter int TILE_W = 6
) (
    input  wire logic              clk,
    input  wire logic              rst,
    input  wire logic              i_load,
    input  wire logic              i_advance,
    input  wire logic [TILE_W-1:0] i_x_max,
    input  wire logic [TILE_W-1:0] i_y_max,
    output logic [TILE_W-1:0]      o_next_x,
    output logic [TILE_W-1:0]      o_next_y,
    output logic                   o_last_tile,
    output logic                   o_next_last
);
    logic [TILE_W-1:0] r_x;
    logic [TILE_W-1:0] r_y;
    logic [TILE_W-1:0] r_x_max;
    logic [TILE_W-1:0] r_y_max;
    logic              w_x_wrap;

    assign w_x_wrap    = (r_x == r_x_max);
    assign o_next_x    = w_x_wrap ? '0 : r_x + TILE_W'(1);
    assign o_next_y    = w_x_wrap ? r_y + TILE_W'(1) : r_y;
    assign o_last_tile = w_x_wrap && (r_y == r_y_max);
    // Lets the owner pre-build the next control word while still on this tile.
    assign o_next_last = (o_next_x == r_x_max) && (o_next_y == r_y_max);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_x     <= '0;
            r_y     <= '0;
            r_x_max <= '0;
            r_y_max <= '0;
        end else if (i_load) begin
            r_x     <= '0;
            r_y     <= '0;
            r_x_max <= i_x_max;
            r_y_max <= i_y_max;
        end else if (i_advance) begin
            r_x     <= o_next_x;
            r_y     <= o_next_y;
        end
    end
endmodule
`default_nettype wire

// File: rtl/ra_writer.sv
`default_nettype none
// ============================================================================
// ra_writer : walks the tile grid and writes one Region Array entry per tile.
// Optional word counter enabled by macro RA_WRITER_STATS_EN.
// Rev 1.0
// ============================================================================
module ra_writer
    import pvr_ra_pkg::*;
#(
    parameter int          ADDR_W    = 24,
    parameter int          TILE_W    = 6,
    parameter logic [31:0] EMPTY_PTR = c_empty_ptr
) (
    input  wire logic              clock,
    input  wire logic              reset,
    input  wire logic              ra_start,
    input  wire logic              fmt_v2,
    input  wire logic [ADDR_W-1:0] region_base,
    input  wire logic [TILE_W-1:0] tiles_x_max,
    input  wire logic [TILE_W-1:0] tiles_y_max,
    input  wire logic              ra_zclear,
    input  wire logic              ra_flush,
    input  wire logic [4:0]        list_en,
    input  wire logic [4:0][31:0]  list_base,
    input  wire logic [31:0]       list_stride,
    ra_writer_if.master            vram,
    output logic                   ra_busy,
    output logic                   ra_done,
    output logic [15:0]            ra_words_written
);
    ra_state_t         r_state;
    logic              r_wr;
    logic              r_busy;
    logic              r_done;
    logic              r_fmt_v2;
    logic              r_zclear;
    logic              r_flush;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_dout;
    logic [31:0]       r_stride;
    logic [4:0]        r_list_en;
    logic [4:0][31:0]  r_acc;
    logic [4:0][31:0]  w_ptr;
    logic              w_start;
    logic              w_xfer;
    logic              w_advance;
    logic              w_last_tile;
    logic              w_next_last;
    logic [TILE_W-1:0] w_next_x;
    logic [TILE_W-1:0] w_next_y;

    assign w_start   = (r_state == RA_IDLE) && ra_start;
    assign w_xfer    = r_wr && !vram.ra_vram_wait;
    assign w_advance = (r_state == RA_NEXT);

    always_comb begin
        w_ptr = '0;
        for (int i = 0; i < 5; i++) begin
            w_ptr[i] = r_list_en[i] ? r_acc[i] : EMPTY_PTR;
        end
    end

    ra_tile_walker #(.TILE_W(TILE_W)) u_walker (
        .clk         (clock),
        .rst         (reset),
        .i_load      (w_start),
        .i_advance   (w_advance),
        .i_x_max     (tiles_x_max),
        .i_y_max     (tiles_y_max),
        .o_next_x    (w_next_x),
        .o_next_y    (w_next_y),
        .o_last_tile (w_last_tile),
        .o_next_last (w_next_last)
    );

    // Each word is registered one state ahead so wr/addr/data leave straight from flops.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state   <= RA_IDLE;
            r_wr      <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_addr    <= '0;
            r_dout    <= '0;
            r_fmt_v2  <= 1'b0;
            r_zclear  <= 1'b0;
            r_flush   <= 1'b0;
            r_list_en <= '0;
            r_stride  <= '0;
            r_acc     <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                RA_IDLE: begin
                    if (ra_start) begin
                        r_state   <= RA_CTRL;
                        r_busy    <= 1'b1;
                        r_wr      <= 1'b1;
                        r_addr    <= region_base;
                        r_dout    <= ra_ctrl_word((tiles_x_max == '0) && (tiles_y_max == '0),
                                                  ra_zclear, ra_flush, 6'd0, 6'd0);
                        r_fmt_v2  <= fmt_v2;
                        r_zclear  <= ra_zclear;
                        r_flush   <= ra_flush;
                        r_list_en <= list_en;
                        r_stride  <= list_stride;
                        r_acc     <= list_base;
                    end
                end
                RA_CTRL, RA_OPQ, RA_OPQM, RA_TRN, RA_TRNM, RA_PT: begin
                    if (w_xfer) begin
                        r_addr <= r_addr + ADDR_W'(4);
                        case (r_state)
                            RA_CTRL: begin r_state <= RA_OPQ;  r_dout <= w_ptr[0]; end
                            RA_OPQ:  begin r_state <= RA_OPQM; r_dout <= w_ptr[1]; end
                            RA_OPQM: begin r_state <= RA_TRN;  r_dout <= w_ptr[2]; end
                            RA_TRN:  begin r_state <= RA_TRNM; r_dout <= w_ptr[3]; end
                            RA_TRNM: begin
                                if (r_fmt_v2) begin
                                    r_state <= RA_PT;
                                    r_dout  <= w_ptr[4];
                                end else begin
                                    r_state <= RA_NEXT;
                                    r_wr    <= 1'b0;
                                end
                            end
                            default: begin r_state <= RA_NEXT; r_wr <= 1'b0; end
                        endcase
                    end
                end
                RA_NEXT: begin
                    for (int i = 0; i < 5; i++) begin
                        r_acc[i] <= r_acc[i] + r_stride;
                    end
                    if (w_last_tile) begin
                        r_state <= RA_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_state <= RA_CTRL;
                        r_wr    <= 1'b1;
                        r_dout  <= ra_ctrl_word(w_next_last, r_zclear, r_flush,
                                                6'(w_next_y), 6'(w_next_x));
                    end
                end
                RA_DONE: r_state <= RA_IDLE;
                default: r_state <= RA_IDLE;
            endcase
        end
    end

    assign vram.ra_vram_wr   = r_wr;
    assign vram.ra_vram_addr = r_addr;
    assign vram.ra_vram_dout = r_dout;
    assign ra_busy           = r_busy;
    assign ra_done           = r_done;

`ifdef RA_WRITER_STATS_EN
    logic [15:0] r_words;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_words <= '0;
        end else if (w_start) begin
            r_words <= '0;
        end else if (w_xfer) begin
            r_words <= r_words + 16'd1;
        end
    end

    assign ra_words_written = r_words;
`else
    assign ra_words_written = 16'd0;
`endif

endmodule
`default_nettype wire
